// File: rtl/grid_controller.sv
// 80x60 two-bit game grid: pixel-rate colour read port plus a round-robin
// serialised trail-write / collision-check port for the two players.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | sweep zeros through every cell, busy=1, no grants
// S_IDLE  | wait for a player request, grant round robin, latch target
// S_READ  | present latched cell address on port B
// S_CHECK | decide lethal/safe from bounds and cell data, write if safe
// S_ACK   | one-cycle ack with crash flag to the granted player
module grid_controller #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int CELL_SHIFT = 3,
    parameter int BORDER     = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       reiniciar,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [1:0] cell_out,
    input  logic       p1_req,
    input  logic [6:0] p1_x,
    input  logic [5:0] p1_y,
    output logic       p1_ack,
    output logic       p1_crash,
    input  logic       p2_req,
    input  logic [6:0] p2_x,
    input  logic [5:0] p2_y,
    output logic       p2_ack,
    output logic       p2_crash,
    output logic       busy
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [12:0] LAST_ADDR = 13'(CELLS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_CHECK,
        S_ACK
    } state_t;

    state_t      state;
    logic [1:0]  mem [0:CELLS-1];
    logic [12:0] clr_addr;
    logic        rein_q;
    logic        prio_p2;
    logic [6:0]  lat_x;
    logic [5:0]  lat_y;
    logic [1:0]  lat_id;
    logic [1:0]  rd_b;
    logic        crash_q;

    logic        rst_edge;
    logic        grant_p2;
    logic [12:0] lat_addr;
    logic        out_of_field;
    logic        lethal;
    logic        we_b;
    logic [12:0] wr_addr;
    logic [1:0]  wr_data;

    logic [9:0]  vga_cx;
    logic [9:0]  vga_cy;
    logic        vga_in;
    logic [12:0] vga_addr;

    // VGA port: independent of the controller, registered, old data on collision
    assign vga_cx   = next_x >> CELL_SHIFT;
    assign vga_cy   = next_y >> CELL_SHIFT;
    assign vga_in   = (next_x < 10'(COLS << CELL_SHIFT)) && (next_y < 10'(ROWS << CELL_SHIFT));
    assign vga_addr = 13'(vga_cy) * 13'(COLS) + 13'(vga_cx);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cell_out <= 2'd0;
        end else begin
            cell_out <= vga_in ? mem[vga_addr] : 2'd0;
        end
    end

    assign rst_edge     = reiniciar & ~rein_q;
    assign grant_p2     = p2_req && (!p1_req || prio_p2);
    assign lat_addr     = 13'(lat_y) * 13'(COLS) + 13'(lat_x);
    assign out_of_field = (lat_x < 7'(BORDER)) || (lat_x >= 7'(COLS - BORDER)) ||
                          (lat_y < 6'(BORDER)) || (lat_y >= 6'(ROWS - BORDER)) ||
                          (lat_x >= 7'(COLS)) || (lat_y >= 6'(ROWS));
    assign lethal       = out_of_field || (rd_b != 2'd0);

    always_comb begin
        we_b    = 1'b0;
        wr_addr = lat_addr;
        wr_data = lat_id;
        if (!rst_edge) begin
            if (state == S_CLEAR) begin
                we_b    = 1'b1;
                wr_addr = clr_addr;
                wr_data = 2'd0;
            end else if (state == S_CHECK && !lethal) begin
                we_b = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (we_b) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= S_CLEAR;
            clr_addr <= 13'd0;
            busy     <= 1'b1;
            p1_ack   <= 1'b0;
            p1_crash <= 1'b0;
            p2_ack   <= 1'b0;
            p2_crash <= 1'b0;
            prio_p2  <= 1'b0;
            rein_q   <= 1'b0;
            lat_x    <= 7'd0;
            lat_y    <= 6'd0;
            lat_id   <= 2'd0;
            rd_b     <= 2'd0;
            crash_q  <= 1'b0;
        end else begin
            rein_q   <= reiniciar;
            p1_ack   <= 1'b0;
            p1_crash <= 1'b0;
            p2_ack   <= 1'b0;
            p2_crash <= 1'b0;
            if (rst_edge) begin
                state    <= S_CLEAR;
                clr_addr <= 13'd0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    S_CLEAR: begin
                        if (clr_addr == LAST_ADDR) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            clr_addr <= clr_addr + 13'd1;
                        end
                    end
                    S_IDLE: begin
                        // ack still visible means the requester has not had a chance to drop req
                        if (!p1_ack && !p2_ack && (p1_req || p2_req)) begin
                            lat_x   <= grant_p2 ? p2_x : p1_x;
                            lat_y   <= grant_p2 ? p2_y : p1_y;
                            lat_id  <= grant_p2 ? 2'd2 : 2'd1;
                            prio_p2 <= !grant_p2;
                            state   <= S_READ;
                        end
                    end
                    S_READ: begin
                        rd_b  <= (lat_addr < 13'(CELLS)) ? mem[lat_addr] : 2'd0;
                        state <= S_CHECK;
                    end
                    S_CHECK: begin
                        crash_q <= lethal;
                        state   <= S_ACK;
                    end
                    S_ACK: begin
                        if (lat_id == 2'd2) begin
                            p2_ack   <= 1'b1;
                            p2_crash <= crash_q;
                        end else begin
                            p1_ack   <= 1'b1;
                            p1_crash <= crash_q;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_CLEAR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grid_controller.sv
// Directed bench for grid_controller: a grid model predicts each ack/crash and
// each VGA read; expectations are queued on drive and popped on DUT output.
module tb_grid_controller;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       reiniciar;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [1:0] cell_out;
    logic       p1_req;
    logic [6:0] p1_x;
    logic [5:0] p1_y;
    logic       p1_ack;
    logic       p1_crash;
    logic       p2_req;
    logic [6:0] p2_x;
    logic [5:0] p2_y;
    logic       p2_ack;
    logic       p2_crash;
    logic       busy;

    grid_controller dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .reiniciar(reiniciar),
        .next_x   (next_x),
        .next_y   (next_y),
        .cell_out (cell_out),
        .p1_req   (p1_req),
        .p1_x     (p1_x),
        .p1_y     (p1_y),
        .p1_ack   (p1_ack),
        .p1_crash (p1_crash),
        .p2_req   (p2_req),
        .p2_x     (p2_x),
        .p2_y     (p2_y),
        .p2_ack   (p2_ack),
        .p2_crash (p2_crash),
        .busy     (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] model [0:4799];
    int         last_grant;
    logic [1:0] vga_q [$];
    logic [2:0] tx_q  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_cell(input int x, input int y);
        if (x >= 640 || y >= 480) return 2'd0;
        return model[(y / 8) * 80 + (x / 8)];
    endfunction

    function automatic logic lethal(input int x, input int y);
        if (x < 2 || x >= 78 || y < 2 || y >= 58) return 1'b1;
        return model[y * 80 + x] != 2'd0;
    endfunction

    task automatic expect_tx(input int id, input int x, input int y);
        logic c;
        c = lethal(x, y);
        tx_q.push_back({2'(id), c});
        if (!c) model[y * 80 + x] = 2'(id);
        last_grant = id;
    endtask

    task automatic probe(input int x, input int y);
        logic [1:0] e;
        next_x = 10'(x);
        next_y = 10'(y);
        vga_q.push_back(exp_cell(x, y));
        @(negedge CLOCK_50);
        e = vga_q.pop_front();
        check($sformatf("cell_out(%0d,%0d)", x, y), 32'(cell_out), 32'(e));
    endtask

    task automatic serve(input int n, output int lat);
        int cnt;
        int got;
        logic [2:0] e;
        cnt = 0;
        got = 0;
        lat = -1;
        while (got < n && cnt < 100) begin
            @(posedge CLOCK_50);
            cnt++;
            @(negedge CLOCK_50);
            if (p1_ack || p2_ack) begin
                if (tx_q.size() == 0) begin
                    check("unexpected_ack", 32'(p1_ack) + 32'(p2_ack) * 2, 0);
                end else begin
                    e = tx_q.pop_front();
                    check("ack_id", 32'(p1_ack) + 32'(p2_ack) * 2, 32'(e[2:1]));
                    check("crash", p1_ack ? 32'(p1_crash) : 32'(p2_crash), 32'(e[0]));
                end
                if (p1_ack) p1_req = 1'b0;
                if (p2_ack) p2_req = 1'b0;
                if (got == 0) lat = cnt;
                got++;
            end
        end
        check("acks_received", got, n);
    endtask

    task automatic single(input int id, input int x, input int y, input bit chk_lat);
        int lat;
        expect_tx(id, x, y);
        if (id == 1) begin
            p1_x = 7'(x); p1_y = 6'(y); p1_req = 1'b1;
        end else begin
            p2_x = 7'(x); p2_y = 6'(y); p2_req = 1'b1;
        end
        serve(1, lat);
        if (chk_lat) check("ack_latency", lat, 4);
    endtask

    task automatic pair(input int x, input int y);
        int first;
        int lat;
        first = (last_grant == 1) ? 2 : 1;
        expect_tx(first, x, y);
        expect_tx(3 - first, x, y);
        p1_x = 7'(x); p1_y = 6'(y);
        p2_x = 7'(x); p2_y = 6'(y);
        p1_req = 1'b1;
        p2_req = 1'b1;
        serve(2, lat);
    endtask

    task automatic count_clear(input string tag);
        int cnt;
        bit saw_ack;
        cnt = 0;
        saw_ack = 0;
        while (cnt < 6000) begin
            @(posedge CLOCK_50);
            cnt++;
            @(negedge CLOCK_50);
            if (p1_ack || p2_ack) saw_ack = 1;
            if (!busy) break;
        end
        check(tag, cnt, 4800);
        check("no_ack_during_clear", 32'(saw_ack), 0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 4800; i++) model[i] = 2'd0;
        last_grant = 2;
        reset = 1'b0;
        reiniciar = 1'b0;
        next_x = '0; next_y = '0;
        p1_req = 1'b0; p1_x = '0; p1_y = '0;
        p2_req = 1'b0; p2_x = '0; p2_y = '0;

        repeat (3) @(negedge CLOCK_50);
        check("reset_busy", 32'(busy), 1);
        check("reset_cell_out", 32'(cell_out), 0);
        check("reset_acks", {p1_ack, p1_crash, p2_ack, p2_crash}, 0);
        reset = 1'b1;
        count_clear("clear_cycles");

        for (int cy = 0; cy < 60; cy++)
            for (int cx = 0; cx < 80; cx++)
                probe(cx * 8 + (cy % 8), cy * 8 + (cx % 8));
        probe(640, 0);
        probe(0, 480);
        probe(1023, 1023);

        single(1, 10, 10, 1);
        for (int i = 0; i < 8; i++) probe(80 + i, 87 - i);
        probe(88, 80);
        probe(80, 88);
        probe(79, 80);
        probe(720, 72);

        single(1, 10, 10, 0);
        probe(84, 84);

        single(2, 1, 30, 0);
        single(2, 78, 5, 0);
        single(2, 40, 0, 0);
        single(2, 40, 58, 0);
        probe(8, 240);
        probe(624, 40);
        probe(320, 0);
        probe(320, 464);

        pair(20, 30);
        probe(160, 240);
        single(1, 10, 10, 0);
        pair(21, 30);
        probe(168, 240);
        probe(175, 247);

        p1_x = 7'd30; p1_y = 6'd30; p1_req = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reiniciar = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("restart_busy", 32'(busy), 1);
        check("restart_no_ack", 32'(p1_ack), 0);
        reiniciar = 1'b0;
        count_clear("restart_clear_cycles");
        for (int i = 0; i < 4800; i++) model[i] = 2'd0;
        expect_tx(1, 30, 30);
        serve(1, lat);
        check("restart_ack_latency", lat, 4);
        probe(80, 80);
        probe(160, 240);
        probe(168, 240);
        probe(240, 240);

        check("queues_drained", tx_q.size() + vga_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
